load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
Memory-stage load unit for the 32-bit datapath. It accepts a load request from execute, issues one word-aligned read to data memory, and waits for the response with a bounded timeout. It then selects the addressed byte or halfword lane and sign- or zero-extends it. The result is held for register writeback under a valid/ready handshake.

Parameters:
TIMEOUT, 255, max WAIT_MEM cycles without mem_rvalid before a timeout error; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT+1) (min 1), timeout counter width; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  load request valid
req_ready  out  1  unit can accept a request
req_addr  in  32  byte address
req_op  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
req_rd  in  5  destination register
mem_rd_en  out  1  one-cycle read strobe
mem_addr  out  32  word address: {req_addr[31:2],2'b00}
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data word
wb_valid  out  1  writeback result valid
wb_ready  in  1  writeback accepts result
wb_data  out  32  extended load result
wb_rd  out  5  destination register
wb_err  out  2  0 none, 1 misaligned, 2 timeout, 3 illegal op

Behaviour:
- Reset (async, rst_n=0): state IDLE. req_ready=1. mem_rd_en=0, mem_addr=0. wb_valid=0, wb_data=0, wb_rd=0, wb_err=0. Counter=0.
- States: IDLE, WAIT_MEM, WB.
- IDLE:
  - req_ready=1. A request is accepted on req_valid&req_ready. Address, op and rd are captured.
  - Illegal op -> WB next cycle with wb_err=3.
  - LH with addr[0]=1, or LW with addr[1:0]!=0 -> WB next cycle with wb_err=1.
  - In both error cases mem_rd_en is never asserted and wb_data=0.
  - Otherwise -> WAIT_MEM. mem_rd_en=1 for the first WAIT_MEM cycle only; mem_addr is held for the whole WAIT_MEM.
- WAIT_MEM:
  - req_ready=0. mem_rvalid is sampled every cycle, including the strobe cycle.
  - On mem_rvalid: extract, extend, register into wb_data -> WB, wb_err=0.
  - Counter counts WAIT_MEM cycles from 1. If it reaches TIMEOUT with no rvalid -> WB, wb_err=2, wb_data=0.
  - rvalid in the TIMEOUT-th cycle wins over the timeout.
- WB:
  - wb_valid=1. wb_data, wb_rd and wb_err stay stable until wb_ready.
  - On wb_valid&wb_ready -> IDLE; wb_valid drops next cycle.
  - req_ready=0 in WB, so there is no back-to-back overlap. Throughput is one load per 2+latency cycles minimum.
- Latency: accept at cycle 0, strobe at cycle 1, rvalid at cycle k>=1 -> wb_valid at k+1. Error paths -> wb_valid at cycle 1.
- Lanes (little-endian): addr[1:0]=0 -> bits 7:0, 1 -> 15:8, 2 -> 23:16, 3 -> 31:24. Halfword: addr[1]=0 -> 15:0, 1 -> 31:16.
- Extension: LB and LH replicate the lane MSB into the upper bits. LBU and LHU fill with zeros. LW passes the word through.
- mem_rvalid while in IDLE or WB is ignored, including late responses after a timeout.
- Reset mid-operation: return to IDLE immediately. Any pending response is dropped and no writeback is produced.

Decomposition:
- Shared package cpu_mem_pkg:
  - load op encodings (LB/LH/LW/LBU/LHU)
  - wb_err codes
  - state enum
- One combinational sub-module, load_extend. Inputs: word, addr[1:0], op. Output: 32-bit extended result. It generalises the existing halfword zero-extension block to every load type.

Test Plan:
- LHU addr 0x00001002, mem_rdata 0x8899AABB at k=2 -> mem_addr 0x00001000, one strobe; wb_data 0x00008899, wb_err 0, wb_valid at cycle 3.
- LH same address and data -> wb_data 0xFFFF8899. LB addr 0x1001 -> 0xFFFFFFAA. LBU addr 0x1003 -> 0x00000088. LW addr 0x1000 -> 0x8899AABB.
- LW addr 0x1001; LH addr 0x1003; op 3'b011 -> no mem_rd_en; wb_valid at cycle 1 with wb_err 1, 1, 3 and wb_data 0.
- TIMEOUT=4, no rvalid -> wb_valid at cycle 5 with wb_err 2. Then a late rvalid in WB or IDLE is ignored. Separately, rvalid at cycle 4 -> normal data, wb_err 0.
- wb_ready held low 3 cycles -> wb_valid, wb_data, wb_rd stable; req_ready 0 throughout; next req accepted the cycle after the handshake.
- rst_n low during WAIT_MEM, then rvalid after release -> all outputs at reset values, no wb_valid, req_ready=1.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_mem_pkg
//  Purpose  : Shared definitions for the memory-stage load path:
//             load op encodings, writeback error codes, load FSM states
//             and the request error decoder.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_mem_pkg;

    // Load op encodings (req_op)
    localparam logic [2:0] c_OP_LB  = 3'b000;
    localparam logic [2:0] c_OP_LH  = 3'b001;
    localparam logic [2:0] c_OP_LW  = 3'b010;
    localparam logic [2:0] c_OP_LBU = 3'b100;
    localparam logic [2:0] c_OP_LHU = 3'b101;

    // Writeback error codes (wb_err)
    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_MISALIGN = 2'd1;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] c_ERR_ILLEGAL  = 2'd3;

    // Load unit FSM states, explicitly encoded
    typedef enum logic [1:0] {
        c_ST_IDLE     = 2'd0,
        c_ST_WAIT_MEM = 2'd1,
        c_ST_WB       = 2'd2
    } state_t;

    // Classify a request before any memory access is issued.
    // Halfword loads of either signedness need addr[0]=0 because the lane
    // select only looks at addr[1]; an odd halfword would silently read
    // the wrong bytes.
    function automatic logic [1:0] decode_err(input logic [2:0] op,
                                              input logic [1:0] addr_lo);
        logic [1:0] err;
        err = c_ERR_NONE;
        case (op)
            c_OP_LB, c_OP_LBU: err = c_ERR_NONE;
            c_OP_LH, c_OP_LHU: if (addr_lo[0]) err = c_ERR_MISALIGN;
            c_OP_LW:           if (addr_lo != 2'b00) err = c_ERR_MISALIGN;
            default:           err = c_ERR_ILLEGAL;
        endcase
        return err;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Combinational lane select and sign/zero extension of a
//             32-bit little-endian memory word for every load type.
//  Ports    : word   - raw word returned by data memory
//             addr   - low two bits of the byte address
//             op     - load op encoding
//             result - extended 32-bit load result (0 for illegal ops)
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
    import cpu_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  op,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (addr)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = addr[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = '0;
        case (op)
            c_OP_LB:  result = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: result = {24'd0, w_byte};
            c_OP_LH:  result = {{16{w_half[15]}}, w_half};
            c_OP_LHU: result = {16'd0, w_half};
            c_OP_LW:  result = word;
            default:  result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_align_unit
//  Purpose  : Memory-stage load unit. Accepts one load request, issues a
//             single word-aligned read, waits for the response with a
//             bounded timeout, extracts/extends the addressed lane and
//             holds the result for writeback under valid/ready.
//  Ports    : clk, rst_n                     - clock / async active-low reset
//             req_valid/ready/addr/op/rd     - request from execute
//             mem_rd_en/addr, mem_rvalid/rdata - data memory read port
//             wb_valid/ready/data/rd/err     - writeback result
//  Revision : 1.0  initial release
// ============================================================================
module load_align_unit
    import cpu_mem_pkg::*;
#(
    parameter  int TIMEOUT = 255,
    localparam int CNT_W   = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1)
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rd,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic [1:0]  wb_err
);

    localparam logic [CNT_W-1:0] c_TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_strobe;
    logic [29:0]      r_word_addr;
    logic [1:0]       r_addr_lo;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_wb_data;
    logic [4:0]       r_wb_rd;
    logic [1:0]       r_wb_err;

    logic             w_accept;
    logic [1:0]       w_req_err;
    logic             w_timeout;
    logic [31:0]      w_ext;

    assign w_accept  = (r_state == c_ST_IDLE) && req_valid;
    assign w_req_err = decode_err(req_op, req_addr[1:0]);
    // r_cnt holds the index of the current WAIT_MEM cycle (first = 1)
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_TIMEOUT_CNT);

    load_extend u_extend (
        .word   (mem_rdata),
        .addr   (r_addr_lo),
        .op     (r_op),
        .result (w_ext)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = (w_req_err != c_ERR_NONE) ? c_ST_WB : c_ST_WAIT_MEM;
                end
            end
            c_ST_WAIT_MEM: begin
                // a response in the final allowed cycle still wins
                if (mem_rvalid || w_timeout) begin
                    w_next_state = c_ST_WB;
                end
            end
            c_ST_WB: begin
                if (wb_ready) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        req_ready = (r_state == c_ST_IDLE);
        wb_valid  = (r_state == c_ST_WB);
        mem_rd_en = r_strobe;
        mem_addr  = {r_word_addr, 2'b00};
        wb_data   = r_wb_data;
        wb_rd     = r_wb_rd;
        wb_err    = r_wb_err;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strobe    <= 1'b0;
            r_word_addr <= '0;
            r_addr_lo   <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_wb_data   <= '0;
            r_wb_rd     <= '0;
            r_wb_err    <= c_ERR_NONE;
        end else begin
            // the read strobe lasts exactly one cycle after acceptance
            r_strobe <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_wb_rd <= req_rd;
                        if (w_req_err != c_ERR_NONE) begin
                            r_wb_err  <= w_req_err;
                            r_wb_data <= '0;
                        end else begin
                            r_strobe    <= 1'b1;
                            r_word_addr <= req_addr[31:2];
                            r_addr_lo   <= req_addr[1:0];
                            r_op        <= req_op;
                            r_cnt       <= CNT_W'(1);
                        end
                    end
                end
                c_ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        r_wb_data <= w_ext;
                        r_wb_err  <= c_ERR_NONE;
                        r_cnt     <= '0;
                    end else if (w_timeout) begin
                        r_wb_data <= '0;
                        r_wb_err  <= c_ERR_TIMEOUT;
                        r_cnt     <= '0;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_align_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_align_unit
//  Purpose  : Self-checking bench for load_align_unit (TIMEOUT = 4).
//             Expected results go into a scoreboard queue when a load is
//             driven and are popped when the unit presents writeback.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_align_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  err;
        int          lat;
    } sb_t;

    typedef struct {
        int          wb_cyc;
        int          strobes;
        logic [31:0] maddr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  err;
        bit          stable;
        bit          rr_low;
        logic        accepted;
        logic        post_valid;
        logic        post_ready;
    } obs_t;

    sb_t sb[$];

    load_align_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_err     (wb_err)
    );

    always #5 clk = ~clk;

    // Drives one load. Cycle c counts clock edges after the accepting edge;
    // mem_rvalid is presented for edge k (k=0: never). wb_ready is raised
    // once wb_valid has been seen for ready_delay cycles.
    task automatic run_load(input logic [31:0] addr, input logic [2:0] op,
                            input logic [4:0] rd, input int k,
                            input logic [31:0] rdata, input int ready_delay,
                            output obs_t o);
        int  wcnt;
        bit  done;
        o.wb_cyc = -1; o.strobes = 0; o.maddr = '0; o.data = '0; o.rd = '0;
        o.err = '0; o.stable = 1'b1; o.rr_low = 1'b1;
        wcnt = 0; done = 1'b0;
        @(negedge clk);
        o.accepted = req_ready;
        req_valid = 1'b1; req_addr = addr; req_op = op; req_rd = rd;
        mem_rdata = rdata; wb_ready = 1'b0; mem_rvalid = (k == 0) ? 1'b0 : 1'b0;
        for (int c = 1; c <= 40 && !done; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (req_ready !== 1'b0) o.rr_low = 1'b0;
            if (mem_rd_en === 1'b1) begin o.strobes++; o.maddr = mem_addr; end
            mem_rvalid = (c == k);
            if (wb_valid === 1'b1) begin
                if (wcnt == 0) begin
                    o.wb_cyc = c; o.data = wb_data; o.rd = wb_rd; o.err = wb_err;
                end else if (wb_data !== o.data || wb_rd !== o.rd || wb_err !== o.err) begin
                    o.stable = 1'b0;
                end
                if (wcnt == ready_delay) begin wb_ready = 1'b1; done = 1'b1; end
                wcnt++;
            end
        end
        @(negedge clk);
        wb_ready = 1'b0; mem_rvalid = 1'b0;
        o.post_valid = wb_valid; o.post_ready = req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err} !== {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 2'd0}) begin
            fails++;
            $display("FAIL reset_in: rr=%b en=%b ma=%h v=%b d=%h rd=%0d e=%0d, want rr=1 rest 0",
                     req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err} !== {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 2'd0}) begin
            fails++;
            $display("FAIL reset_idle: rr=%b en=%b ma=%h v=%b d=%h rd=%0d e=%0d, want rr=1 rest 0",
                     req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] addr_t [7] = '{32'h1002, 32'h1002, 32'h1001, 32'h1003, 32'h1000, 32'h1000, 32'h1002};
        logic [2:0]  op_t   [7] = '{3'b101, 3'b001, 3'b000, 3'b100, 3'b010, 3'b101, 3'b000};
        logic [31:0] want_t [7] = '{32'h00008899, 32'hFFFF8899, 32'hFFFFFFAA, 32'h00000088,
                                    32'h8899AABB, 32'h0000AABB, 32'hFFFFFF99};
        int          k_t    [7] = '{2, 2, 2, 1, 3, 2, 1};
        logic [31:0] a;
        obs_t o;
        sb_t  e;
        for (int i = 0; i < 7; i++) begin
            a = addr_t[i];
            sb.push_back('{data: want_t[i], rd: 5'(i + 1), err: 2'd0, lat: k_t[i] + 1});
            run_load(a, op_t[i], 5'(i + 1), k_t[i], 32'h8899AABB, 0, o);
            e = sb.pop_front();
            tests++;
            if (o.accepted !== 1'b1 || {o.data, o.rd, o.err} !== {e.data, e.rd, e.err}) begin
                fails++;
                $display("FAIL lane[%0d] result: acc=%b data=%h rd=%0d err=%0d, want data=%h rd=%0d err=%0d",
                         i, o.accepted, o.data, o.rd, o.err, e.data, e.rd, e.err);
            end
            tests++;
            if (o.wb_cyc != e.lat) begin
                fails++;
                $display("FAIL lane[%0d] latency: wb_valid at %0d, want %0d", i, o.wb_cyc, e.lat);
            end
            tests++;
            if (o.strobes != 1 || o.maddr !== {a[31:2], 2'b00}) begin
                fails++;
                $display("FAIL lane[%0d] read: strobes=%0d mem_addr=%h, want 1 at %h",
                         i, o.strobes, o.maddr, {a[31:2], 2'b00});
            end
            tests++;
            if (o.post_valid !== 1'b0 || o.post_ready !== 1'b1 || !o.rr_low) begin
                fails++;
                $display("FAIL lane[%0d] handshake: post_valid=%b post_ready=%b busy_low=%b, want 0 1 1",
                         i, o.post_valid, o.post_ready, o.rr_low);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] addr_t [3] = '{32'h1001, 32'h1003, 32'h1000};
        logic [2:0]  op_t   [3] = '{3'b010, 3'b001, 3'b011};
        logic [1:0]  err_t  [3] = '{2'd1, 2'd1, 2'd3};
        obs_t o;
        sb_t  e;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{data: 32'd0, rd: 5'(20 + i), err: err_t[i], lat: 1});
            run_load(addr_t[i], op_t[i], 5'(20 + i), 1, 32'hCAFEF00D, 0, o);
            e = sb.pop_front();
            tests++;
            if ({o.data, o.rd, o.err} !== {e.data, e.rd, e.err} || o.wb_cyc != e.lat) begin
                fails++;
                $display("FAIL err[%0d]: data=%h rd=%0d err=%0d at %0d, want data=%h rd=%0d err=%0d at %0d",
                         i, o.data, o.rd, o.err, o.wb_cyc, e.data, e.rd, e.err, e.lat);
            end
            tests++;
            if (o.strobes != 0) begin
                fails++;
                $display("FAIL err[%0d] strobe: strobes=%0d, want 0", i, o.strobes);
            end
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        sb_t  e;
        // no response; a late rvalid arrives while the error is in WB
        sb.push_back('{data: 32'd0, rd: 5'd9, err: 2'd2, lat: 5});
        run_load(32'h3000, 3'b010, 5'd9, 6, 32'hDEADBEEF, 2, o);
        e = sb.pop_front();
        tests++;
        if ({o.data, o.rd, o.err} !== {e.data, e.rd, e.err} || o.wb_cyc != e.lat || !o.stable) begin
            fails++;
            $display("FAIL timeout: data=%h rd=%0d err=%0d at %0d stable=%b, want data=%h rd=%0d err=%0d at %0d stable=1",
                     o.data, o.rd, o.err, o.wb_cyc, o.stable, e.data, e.rd, e.err, e.lat);
        end
        // stray rvalid in IDLE
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        tests++;
        if (wb_valid !== 1'b0 || req_ready !== 1'b1 || mem_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL idle_rvalid: wb_valid=%b req_ready=%b rd_en=%b, want 0 1 0",
                     wb_valid, req_ready, mem_rd_en);
        end
        // response in the last allowed cycle beats the timeout
        sb.push_back('{data: 32'hFFFFBEEF, rd: 5'd10, err: 2'd0, lat: 5});
        run_load(32'h3000, 3'b001, 5'd10, 4, 32'hDEADBEEF, 0, o);
        e = sb.pop_front();
        tests++;
        if ({o.data, o.rd, o.err} !== {e.data, e.rd, e.err} || o.wb_cyc != e.lat) begin
            fails++;
            $display("FAIL rvalid_at_limit: data=%h rd=%0d err=%0d at %0d, want data=%h rd=%0d err=%0d at %0d",
                     o.data, o.rd, o.err, o.wb_cyc, e.data, e.rd, e.err, e.lat);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        sb_t  e;
        sb.push_back('{data: 32'h0000007F, rd: 5'd17, err: 2'd0, lat: 2});
        run_load(32'h4003, 3'b000, 5'd17, 1, 32'h7F123456, 3, o);
        e = sb.pop_front();
        tests++;
        if ({o.data, o.rd, o.err} !== {e.data, e.rd, e.err} || o.wb_cyc != e.lat) begin
            fails++;
            $display("FAIL bp_result: data=%h rd=%0d err=%0d at %0d, want data=%h rd=%0d err=%0d at %0d",
                     o.data, o.rd, o.err, o.wb_cyc, e.data, e.rd, e.err, e.lat);
        end
        tests++;
        if (!o.stable || !o.rr_low || o.post_valid !== 1'b0 || o.post_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_hold: stable=%b busy_low=%b post_valid=%b post_ready=%b, want 1 1 0 1",
                     o.stable, o.rr_low, o.post_valid, o.post_ready);
        end
        // next request goes in as soon as the unit reports ready again
        sb.push_back('{data: 32'h00001234, rd: 5'd18, err: 2'd0, lat: 2});
        run_load(32'h4000, 3'b101, 5'd18, 1, 32'h7F121234, 0, o);
        e = sb.pop_front();
        tests++;
        if (o.accepted !== 1'b1 || {o.data, o.rd, o.err} !== {e.data, e.rd, e.err} || o.wb_cyc != e.lat) begin
            fails++;
            $display("FAIL bp_next: acc=%b data=%h rd=%0d err=%0d at %0d, want acc=1 data=%h rd=%0d err=%0d at %0d",
                     o.accepted, o.data, o.rd, o.err, o.wb_cyc, e.data, e.rd, e.err, e.lat);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_wb;
        seen_wb = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h5004; req_op = 3'b010; req_rd = 5'd7;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err} !== {1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 2'd0}) begin
            fails++;
            $display("FAIL mid_reset: rr=%b en=%b ma=%h v=%b d=%h rd=%0d e=%0d, want rr=1 rest 0",
                     req_ready, mem_rd_en, mem_addr, wb_valid, wb_data, wb_rd, wb_err);
        end
        @(negedge clk);
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (wb_valid !== 1'b0) seen_wb = 1'b1;
        end
        tests++;
        if (seen_wb || {req_ready, mem_rd_en, mem_addr, wb_data, wb_rd, wb_err} !== {1'b1, 1'b0, 32'd0, 32'd0, 5'd0, 2'd0}) begin
            fails++;
            $display("FAIL post_reset_rvalid: wb_seen=%b rr=%b en=%b ma=%h d=%h rd=%0d e=%0d, want none, rr=1 rest 0",
                     seen_wb, req_ready, mem_rd_en, mem_addr, wb_data, wb_rd, wb_err);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_op = '0; req_rd = '0;
        mem_rvalid = 1'b0; mem_rdata = '0; wb_ready = 1'b0;
        test_reset();
        test_lanes();
        test_errors();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
